// File: rtl/cu_pkg.sv
// Shared types for the 9-bit processor control unit: opcodes, step encoding
// and instruction-register field positions.
package cu_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable; drives the register-file
// load enables.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y[idx] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing control unit: decodes IR and the external step count
// into datapath strobes. Define CU_ILLEGAL_FLAG_EN to add the sticky `illegal` output.
//
// step | meaning
// T0   | fetch: load IR when run, arm the instruction
// T1   | mv/mvi/illegal complete; add/sub latch operand X into A
// T2   | add/sub: operand Y through ALU into G
// T3   | add/sub: write G back to Rx, complete
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic [8:0] ir,
  input  logic [1:0] state,
  output logic       ain,
  output logic       gin,
  output logic       sub,
  output logic [7:0] rin,
  output logic [2:0] rout,
  output logic       din_en,
  output logic       gout,
  output logic       ir_en,
  output logic       clear,
`ifdef CU_ILLEGAL_FLAG_EN
  output logic       illegal,
`endif
  output logic       done
);

  logic       active;
  logic       rin_en;
  logic [2:0] op;
  logic [2:0] x_idx;
  logic [2:0] y_idx;
  logic       is_alu;
  step_e      step;

  assign op     = ir[OP_MSB:OP_LSB];
  assign x_idx  = ir[X_MSB:X_LSB];
  assign y_idx  = ir[Y_MSB:Y_LSB];
  assign step   = step_e'(state);
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);

  // Everything is qualified by resetn so the datapath is quiet while held in reset.
  always_comb begin
    ain    = 1'b0;
    gin    = 1'b0;
    sub    = 1'b0;
    rout   = 3'b000;
    din_en = 1'b0;
    gout   = 1'b0;
    ir_en  = 1'b0;
    done   = 1'b0;
    rin_en = 1'b0;
    if (resetn) begin
      case (step)
        T0: ir_en = run;
        T1: begin
          if (active) begin
            case (op)
              OP_MV: begin
                rout   = y_idx;
                rin_en = 1'b1;
                done   = 1'b1;
              end
              OP_MVI: begin
                din_en = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
              end
              OP_ADD, OP_SUB: begin
                rout = x_idx;
                ain  = 1'b1;
              end
              default: done = 1'b1;
            endcase
          end
        end
        T2: begin
          if (active && is_alu) begin
            rout = y_idx;
            gin  = 1'b1;
            sub  = (op == OP_SUB);
          end
        end
        T3: begin
          if (active && is_alu) begin
            gout   = 1'b1;
            rin_en = 1'b1;
            done   = 1'b1;
          end
        end
        default: ;
      endcase
    end
    clear = ~resetn | done | ((step == T0) & ~run);
  end

  dec3to8 u_rin_dec (
    .en  (rin_en),
    .idx (x_idx),
    .y   (rin)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
    end else if ((step == T0) && run) begin
      active <= 1'b1;
    end else if (done) begin
      active <= 1'b0;
    end
  end

`ifdef CU_ILLEGAL_FLAG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      illegal <= 1'b0;
    end else if (active && (step == T1) && op[2]) begin
      illegal <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: one vector per clock cycle, outputs
// checked mid-cycle before the edge that advances the internal active flag.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       resetn;
  logic       run;
  logic [8:0] ir;
  logic [1:0] state;
  logic       ain, gin, sub, din_en, gout, ir_en, clear, done;
  logic [7:0] rin;
  logic [2:0] rout;
`ifdef CU_ILLEGAL_FLAG_EN
  logic       illegal;
`endif

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .ir     (ir),
    .state  (state),
    .ain    (ain),
    .gin    (gin),
    .sub    (sub),
    .rin    (rin),
    .rout   (rout),
    .din_en (din_en),
    .gout   (gout),
    .ir_en  (ir_en),
    .clear  (clear),
`ifdef CU_ILLEGAL_FLAG_EN
    .illegal(illegal),
`endif
    .done   (done)
  );

  always #5 clk = ~clk;

  // Packed output word: {ain,gin,sub,rin[7:0],rout[2:0],din_en,gout,ir_en,clear,done}
  typedef struct {
    string      name;
    logic       rstn;
    logic       run;
    logic [8:0] ir;
    logic [1:0] st;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [18:0] mk(input logic a, input logic g, input logic s,
                                     input logic [7:0] ri, input logic [2:0] ro,
                                     input logic di, input logic go, input logic ie,
                                     input logic cl, input logic dn);
    return {a, g, s, ri, ro, di, go, ie, cl, dn};
  endfunction

  function automatic logic [18:0] outs();
    return {ain, gin, sub, rin, rout, din_en, gout, ir_en, clear, done};
  endfunction

  task automatic add_vec(input string n, input logic rs, input logic rn,
                         input logic [8:0] i, input logic [1:0] s, input logic [18:0] e);
    vec_t v;
    v.name = n; v.rstn = rs; v.run = rn; v.ir = i; v.st = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b (ain gin sub rin rout din gout iren clr done)",
               n, got, exp);
    end
  endtask

  task automatic step_cycle(input logic rs, input logic rn, input logic [8:0] i,
                            input logic [1:0] s);
    @(negedge clk);
    resetn = rs; run = rn; ir = i; state = s;
    #2;
  endtask

  localparam logic [8:0] MV_R2_R0  = 9'b000_010_000;
  localparam logic [8:0] MVI_R1    = 9'b001_001_000;
  localparam logic [8:0] ADD_R2_R3 = 9'b010_010_011;
  localparam logic [8:0] SUB_R4_R5 = 9'b011_100_101;
  localparam logic [8:0] MV_R1_R7  = 9'b000_001_111;
  localparam logic [8:0] ILL_111   = 9'b111_011_010;
  localparam logic [8:0] ADD_R5_R6 = 9'b010_101_110;
  localparam logic [8:0] ADD_R2_R2 = 9'b010_010_010;

  logic [18:0] idle, rst_o, t0_go;

  initial begin
    resetn = 1'b0; run = 1'b1; ir = ADD_R2_R3; state = 2'd2;
    idle  = mk(0,0,0,8'h00,3'd0,0,0,0,0,0);
    rst_o = mk(0,0,0,8'h00,3'd0,0,0,0,1,0);
    t0_go = mk(0,0,0,8'h00,3'd0,0,0,1,0,0);

    add_vec("rst_t2",      0, 1, ADD_R2_R3, 2'd2, rst_o);
    add_vec("rst_t0",      0, 1, MV_R2_R0,  2'd0, rst_o);
    add_vec("mv_t0",       1, 1, MV_R2_R0,  2'd0, t0_go);
    add_vec("mv_t1",       1, 1, MV_R2_R0,  2'd1, mk(0,0,0,8'h04,3'd0,0,0,0,1,1));
    add_vec("norun_t0",    1, 0, MVI_R1,    2'd0, rst_o);
    add_vec("norun_t1",    1, 0, MVI_R1,    2'd1, idle);
    add_vec("runpulse_t1", 1, 1, MVI_R1,    2'd1, idle);
    add_vec("mvi_t0",      1, 1, MVI_R1,    2'd0, t0_go);
    add_vec("mvi_t1",      1, 0, MVI_R1,    2'd1, mk(0,0,0,8'h02,3'd0,1,0,0,1,1));
    add_vec("add_t0",      1, 1, ADD_R2_R3, 2'd0, t0_go);
    add_vec("add_t1",      1, 0, ADD_R2_R3, 2'd1, mk(1,0,0,8'h00,3'd2,0,0,0,0,0));
    add_vec("add_t2",      1, 1, ADD_R2_R3, 2'd2, mk(0,1,0,8'h00,3'd3,0,0,0,0,0));
    add_vec("add_t3",      1, 0, ADD_R2_R3, 2'd3, mk(0,0,0,8'h04,3'd0,0,1,0,1,1));
    add_vec("sub_t0",      1, 1, SUB_R4_R5, 2'd0, t0_go);
    add_vec("sub_t1",      1, 0, SUB_R4_R5, 2'd1, mk(1,0,0,8'h00,3'd4,0,0,0,0,0));
    add_vec("sub_t2",      1, 0, SUB_R4_R5, 2'd2, mk(0,1,1,8'h00,3'd5,0,0,0,0,0));
    add_vec("sub_t3",      1, 0, SUB_R4_R5, 2'd3, mk(0,0,0,8'h10,3'd0,0,1,0,1,1));
    add_vec("mv17_t0",     1, 1, MV_R1_R7,  2'd0, t0_go);
    add_vec("mv17_t1",     1, 0, MV_R1_R7,  2'd1, mk(0,0,0,8'h02,3'd7,0,0,0,1,1));
    add_vec("mv17_t2",     1, 0, MV_R1_R7,  2'd2, idle);
    add_vec("ill_t0",      1, 1, ILL_111,   2'd0, t0_go);
    add_vec("ill_t1",      1, 0, ILL_111,   2'd1, mk(0,0,0,8'h00,3'd0,0,0,0,1,1));
    add_vec("ill_t2",      1, 0, ILL_111,   2'd2, idle);
    add_vec("add56_t0",    1, 1, ADD_R5_R6, 2'd0, t0_go);
    add_vec("add56_t1",    1, 0, ADD_R5_R6, 2'd1, mk(1,0,0,8'h00,3'd5,0,0,0,0,0));
    add_vec("add56_rst",   0, 0, ADD_R5_R6, 2'd2, rst_o);
    add_vec("post_rst_t2", 1, 0, ADD_R5_R6, 2'd2, idle);
    add_vec("post_rst_t3", 1, 0, ADD_R5_R6, 2'd3, idle);
    add_vec("wait_t0",     1, 0, ADD_R5_R6, 2'd0, rst_o);

    foreach (vecs[k]) begin
      step_cycle(vecs[k].rstn, vecs[k].run, vecs[k].ir, vecs[k].st);
      check(vecs[k].name, outs(), vecs[k].exp);
    end

    // add R2,R2: same register as source and destination
    step_cycle(1, 1, ADD_R2_R2, 2'd0);
    step_cycle(1, 0, ADD_R2_R2, 2'd1);
    check("dbl_t1", outs(), mk(1,0,0,8'h00,3'd2,0,0,0,0,0));
    step_cycle(1, 0, ADD_R2_R2, 2'd2);
    check("dbl_t2", outs(), mk(0,1,0,8'h00,3'd2,0,0,0,0,0));
    step_cycle(1, 0, ADD_R2_R2, 2'd3);
    check("dbl_t3", outs(), mk(0,0,0,8'h04,3'd0,0,1,0,1,1));

    // asynchronous reset asserted mid-cycle during T2, no clock edge needed
    step_cycle(1, 1, SUB_R4_R5, 2'd0);
    step_cycle(1, 0, SUB_R4_R5, 2'd1);
    step_cycle(1, 0, SUB_R4_R5, 2'd2);
    resetn = 1'b0;
    #1;
    check("async_rst", outs(), rst_o);
    step_cycle(1, 0, SUB_R4_R5, 2'd2);
    check("async_rst_aborted", outs(), idle);

`ifdef CU_ILLEGAL_FLAG_EN
    step_cycle(1, 1, ILL_111, 2'd0);
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_before: got %b required 0", illegal);
    end
    step_cycle(1, 0, ILL_111, 2'd1);
    step_cycle(1, 1, MV_R2_R0, 2'd0);
    checks++;
    if (illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_set: got %b required 1", illegal);
    end
    step_cycle(1, 0, MV_R2_R0, 2'd1);
    step_cycle(1, 0, MV_R2_R0, 2'd0);
    checks++;
    if (illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_sticky: got %b required 1", illegal);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_reset: got %b required 0", illegal);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
